// File: rtl/datapath_gen.sv
// Width-generic 6502-style datapath: register file, ALU with NZCV flags, PC with
// two-cycle page-crossing relative branch, stack pointer with sticky wrap error.
module datapath_gen #(
  parameter int              DW      = 8,
  parameter int              AW      = 16,
  parameter int              NREG    = 4,
  parameter logic [AW-1:0]   PC_INIT = '0,
  parameter logic [DW-1:0]   SP_INIT = '1,
  parameter int              SP_PAGE = 1,
  localparam int             RW      = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [DW-1:0] DB_IN,
  input  logic          IR_WE,
  input  logic [1:0]    PC_CTRL,
  input  logic [RW-1:0] REG_SEL,
  input  logic          REG_WE,
  input  logic [1:0]    REG_SRC,
  input  logic          T_WE,
  input  logic [2:0]    ALU_OP,
  input  logic          FLAG_WE,
  input  logic [1:0]    SP_CTRL,
  input  logic [1:0]    AB_SRC,
  input  logic [2:0]    DB_OUT_SRC,
  output logic [DW-1:0] INSTR,
  output logic [3:0]    FLAG,
  output logic [AW-1:0] AB,
  output logic [DW-1:0] DB_OUT,
  output logic          BUSY,
  output logic          SP_ERR
);

  localparam int HW  = AW - DW;
  localparam int DW1 = DW + 1;
  localparam logic [HW-1:0] STK_PAGE = HW'(SP_PAGE);

  typedef enum logic {IDLE, FIX} state_t;

  state_t          state_q, state_d;
  logic            fwd_q, fwd_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   sp_q, sp_d;
  logic            sp_err_q, sp_err_d;
  logic [DW-1:0]   t_q, instr_q;
  logic [3:0]      flag_q, flag_d;
  logic [AW-1:0]   ab_q, ab_d;
  logic [DW-1:0]   regs_q [NREG];

  logic [DW-1:0]   a_op, alu_res, reg_wdata, stk_sp;
  logic            alu_c, alu_v;
  logic [DW:0]     sum, br_sum;
  logic            br_cross;

  // ALU: A = reg[REG_SEL], B = T; flag_q is {N,Z,C,V}
  always_comb begin
    a_op    = regs_q[REG_SEL];
    sum     = '0;
    alu_res = a_op;
    alu_c   = flag_q[1];
    alu_v   = flag_q[0];
    case (ALU_OP)
      3'd0: begin
        sum     = {1'b0, a_op} + {1'b0, t_q} + DW1'(flag_q[1]);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (a_op[DW-1] == t_q[DW-1]) && (alu_res[DW-1] != a_op[DW-1]);
      end
      3'd1: begin
        // A + ~B + C: carry out set means no borrow
        sum     = {1'b0, a_op} + {1'b0, ~t_q} + DW1'(flag_q[1]);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (a_op[DW-1] != t_q[DW-1]) && (alu_res[DW-1] != a_op[DW-1]);
      end
      3'd2: alu_res = a_op & t_q;
      3'd3: alu_res = a_op | t_q;
      3'd4: alu_res = a_op ^ t_q;
      3'd5: begin
        alu_res = {a_op[DW-2:0], 1'b0};
        alu_c   = a_op[DW-1];
      end
      3'd6: begin
        alu_res = {1'b0, a_op[DW-1:1]};
        alu_c   = a_op[0];
      end
      default: alu_res = a_op;
    endcase
    flag_d = FLAG_WE ? {alu_res[DW-1], (alu_res == '0), alu_c, alu_v} : flag_q;
  end

  // A page is crossed when the low-byte carry disagrees with the offset sign.
  assign br_sum   = {1'b0, pc_q[DW-1:0]} + {1'b0, t_q};
  assign br_cross = (br_sum[DW] != t_q[DW-1]);

  always_comb begin
    state_d = state_q;
    fwd_d   = fwd_q;
    pc_d    = pc_q;
    if (state_q == FIX) begin
      pc_d[AW-1:DW] = fwd_q ? pc_q[AW-1:DW] + HW'(1) : pc_q[AW-1:DW] - HW'(1);
      state_d       = IDLE;
    end else begin
      case (PC_CTRL)
        2'b01: pc_d = pc_q + AW'(1);
        2'b10: pc_d = AW'({DB_IN, t_q});
        2'b11: begin
          pc_d[DW-1:0] = br_sum[DW-1:0];
          if (br_cross) begin
            state_d = FIX;
            fwd_d   = ~t_q[DW-1];
          end
        end
        default: ;
      endcase
    end
  end

  // Stack: push addresses with the old SP, pop with the new one
  always_comb begin
    sp_d     = sp_q;
    sp_err_d = sp_err_q;
    stk_sp   = sp_q;
    case (SP_CTRL)
      2'b01: begin
        sp_d = sp_q - DW'(1);
        if (sp_q == '0) sp_err_d = 1'b1;
      end
      2'b10: begin
        sp_d   = sp_q + DW'(1);
        stk_sp = sp_d;
        if (sp_q == '1) sp_err_d = 1'b1;
      end
      2'b11: sp_d = regs_q[REG_SEL];
      default: ;
    endcase
  end

  always_comb begin
    case (AB_SRC)
      2'b00:   ab_d = pc_d;
      2'b01:   ab_d = AW'({DB_IN, t_q});
      2'b10:   ab_d = {STK_PAGE, stk_sp};
      default: ab_d = ab_q;
    endcase
    case (REG_SRC)
      2'b00:   reg_wdata = DB_IN;
      2'b01:   reg_wdata = alu_res;
      2'b10:   reg_wdata = t_q;
      default: reg_wdata = sp_q;
    endcase
    case (DB_OUT_SRC)
      3'd0:    DB_OUT = regs_q[REG_SEL];
      3'd1:    DB_OUT = t_q;
      3'd2:    DB_OUT = pc_q[DW-1:0];
      3'd3:    DB_OUT = DW'(pc_q[AW-1:DW]);
      3'd4:    DB_OUT = DW'(flag_q);
      default: DB_OUT = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= IDLE;
      fwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fwd_q   <= fwd_d;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pc_q     <= PC_INIT;
      sp_q     <= SP_INIT;
      sp_err_q <= 1'b0;
      t_q      <= '0;
      instr_q  <= '0;
      flag_q   <= '0;
      ab_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      sp_err_q <= sp_err_d;
      flag_q   <= flag_d;
      ab_q     <= ab_d;
      if (T_WE)   t_q              <= DB_IN;
      if (IR_WE)  instr_q          <= DB_IN;
      if (REG_WE) regs_q[REG_SEL]  <= reg_wdata;
    end
  end

  assign INSTR  = instr_q;
  assign FLAG   = flag_q;
  assign AB     = ab_q;
  assign BUSY   = (state_q == FIX);
  assign SP_ERR = sp_err_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Scoreboard bench for datapath_gen: an integer-arithmetic reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_datapath_gen;
  localparam int DW = 8, AW = 16, NREG = 4;

  logic          CLK = 1'b0;
  logic          RES;
  logic [7:0]    DB_IN;
  logic          IR_WE, REG_WE, T_WE, FLAG_WE;
  logic [1:0]    PC_CTRL, REG_SRC, SP_CTRL, AB_SRC;
  logic [1:0]    REG_SEL;
  logic [2:0]    ALU_OP, DB_OUT_SRC;
  logic [7:0]    INSTR, DB_OUT;
  logic [3:0]    FLAG;
  logic [15:0]   AB;
  logic          BUSY, SP_ERR;

  datapath_gen #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .CLK(CLK), .RES(RES), .DB_IN(DB_IN), .IR_WE(IR_WE), .PC_CTRL(PC_CTRL),
    .REG_SEL(REG_SEL), .REG_WE(REG_WE), .REG_SRC(REG_SRC), .T_WE(T_WE),
    .ALU_OP(ALU_OP), .FLAG_WE(FLAG_WE), .SP_CTRL(SP_CTRL), .AB_SRC(AB_SRC),
    .DB_OUT_SRC(DB_OUT_SRC), .INSTR(INSTR), .FLAG(FLAG), .AB(AB),
    .DB_OUT(DB_OUT), .BUSY(BUSY), .SP_ERR(SP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  instr;
    logic [3:0]  flag;
    logic        busy;
    logic        sp_err;
    logic [7:0]  dbo;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Reference model state, plain integers
  int m_pc, m_sp, m_t, m_instr, m_ab, m_dir;
  int m_regs[4];
  bit m_n, m_z, m_c, m_v, m_fix, m_sp_err;

  function automatic void model_reset();
    m_pc = 0; m_sp = 255; m_t = 0; m_instr = 0; m_ab = 0; m_dir = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_fix = 0; m_sp_err = 0;
  endfunction

  function automatic int sx(int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic step();
    exp_t e;
    int a, b, cin, s, ss, res, db;
    bit cnew, vnew;
    int new_pc, new_sp, stk, tgt, wd;
    bit new_fix;
    db = int'(DB_IN);
    e.ab = 16'(m_ab); e.instr = 8'(m_instr); e.flag = {m_n, m_z, m_c, m_v};
    e.busy = m_fix; e.sp_err = m_sp_err;
    case (DB_OUT_SRC)
      3'd0: e.dbo = 8'(m_regs[REG_SEL]);
      3'd1: e.dbo = 8'(m_t);
      3'd2: e.dbo = 8'(m_pc % 256);
      3'd3: e.dbo = 8'(m_pc / 256);
      3'd4: e.dbo = {4'h0, m_n, m_z, m_c, m_v};
      default: e.dbo = 8'h00;
    endcase
    sbq.push_back(e);

    a = m_regs[REG_SEL]; b = m_t; cin = int'(m_c);
    res = a; cnew = m_c; vnew = m_v;
    case (ALU_OP)
      3'd0: begin
        s = a + b + cin; res = s % 256; cnew = (s > 255);
        ss = sx(a) + sx(b) + cin; vnew = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        s = a - b - (1 - cin); res = (s + 256) % 256; cnew = (s >= 0);
        ss = sx(a) - sx(b) - (1 - cin); vnew = (ss > 127) || (ss < -128);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin res = (a * 2) % 256; cnew = (a >= 128); end
      3'd6: begin res = a / 2; cnew = (a % 2 == 1); end
      default: res = a;
    endcase

    new_pc = m_pc; new_fix = 0;
    if (m_fix) begin
      new_pc = (((m_pc / 256) + m_dir + 256) % 256) * 256 + (m_pc % 256);
    end else begin
      case (PC_CTRL)
        2'b01: new_pc = (m_pc + 1) % 65536;
        2'b10: new_pc = db * 256 + m_t;
        2'b11: begin
          tgt = (m_pc % 256) + sx(m_t);
          new_pc = (m_pc / 256) * 256 + ((tgt + 256) % 256);
          if (tgt > 255) begin new_fix = 1; m_dir = 1; end
          else if (tgt < 0) begin new_fix = 1; m_dir = -1; end
        end
        default: ;
      endcase
    end

    new_sp = m_sp; stk = m_sp;
    case (SP_CTRL)
      2'b01: begin
        if (m_sp == 0) begin new_sp = 255; m_sp_err = 1; end else new_sp = m_sp - 1;
      end
      2'b10: begin
        if (m_sp == 255) begin new_sp = 0; m_sp_err = 1; end else new_sp = m_sp + 1;
        stk = new_sp;
      end
      2'b11: new_sp = m_regs[REG_SEL];
      default: ;
    endcase

    case (AB_SRC)
      2'b00: m_ab = new_pc;
      2'b01: m_ab = db * 256 + m_t;
      2'b10: m_ab = 256 + stk;
      default: ;
    endcase

    if (REG_WE) begin
      case (REG_SRC)
        2'b00: wd = db;
        2'b01: wd = res;
        2'b10: wd = m_t;
        default: wd = m_sp;
      endcase
      m_regs[REG_SEL] = wd;
    end
    if (FLAG_WE) begin
      m_n = (res >= 128); m_z = (res == 0); m_c = cnew; m_v = vnew;
    end
    if (T_WE) m_t = db;
    if (IR_WE) m_instr = db;
    m_pc = new_pc; m_sp = new_sp; m_fix = new_fix;
    @(posedge CLK); #2;
  endtask

  task automatic chk(input string nm, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        if (AB !== e.ab || INSTR !== e.instr || FLAG !== e.flag || BUSY !== e.busy ||
            SP_ERR !== e.sp_err || DB_OUT !== e.dbo) begin
          n_miss++;
          $display("FAIL vec%0d at %0t: got AB=%h INSTR=%h FLAG=%b BUSY=%b SP_ERR=%b DB_OUT=%h expected AB=%h INSTR=%h FLAG=%b BUSY=%b SP_ERR=%b DB_OUT=%h",
                   n_vec, $time, AB, INSTR, FLAG, BUSY, SP_ERR, DB_OUT,
                   e.ab, e.instr, e.flag, e.busy, e.sp_err, e.dbo);
        end
      end
    end
  end

  task automatic idle();
    IR_WE = 0; PC_CTRL = 2'b00; REG_SEL = 2'd0; REG_WE = 0; REG_SRC = 2'b00;
    T_WE = 0; ALU_OP = 3'd7; FLAG_WE = 0; SP_CTRL = 2'b00; AB_SRC = 2'b00;
    DB_OUT_SRC = 3'd0; DB_IN = 8'h00;
  endtask

  task automatic set_t(input logic [7:0] v);
    idle(); T_WE = 1; DB_IN = v; step();
  endtask

  task automatic set_pc(input logic [15:0] v);
    set_t(v[7:0]);
    idle(); PC_CTRL = 2'b10; DB_IN = v[15:8]; step();
  endtask

  task automatic set_reg(input logic [1:0] r, input logic [7:0] v);
    idle(); REG_SEL = r; REG_WE = 1; REG_SRC = 2'b00; DB_IN = v; step();
  endtask

  task automatic branch();
    idle(); PC_CTRL = 2'b11; step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge CLK);
    chk("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin : stim
    RES = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #2 RES = 1'b0;

    // reset state
    idle(); AB_SRC = 2'b11; DB_OUT_SRC = 3'd4; step();

    // branch without page cross
    set_pc(16'h1010); set_t(8'h05); branch();
    idle(); DB_OUT_SRC = 3'd2; step();
    idle(); DB_OUT_SRC = 3'd3; step();

    // forward page cross, PC increment requested during fixup
    set_pc(16'h10F0); set_t(8'h20); branch();
    idle(); PC_CTRL = 2'b01; step();
    idle(); step();

    // backward page cross
    set_pc(16'h1005); set_t(8'hF0); branch();
    idle(); step();
    idle(); step();

    // ALU overflow / borrow flags
    set_reg(2'd0, 8'h7F); set_t(8'h01);
    idle(); ALU_OP = 3'd0; FLAG_WE = 1; REG_WE = 1; REG_SRC = 2'b01; step();
    idle(); DB_OUT_SRC = 3'd4; step();
    idle(); step();
    set_reg(2'd0, 8'hFF);
    idle(); ALU_OP = 3'd0; FLAG_WE = 1; step();
    set_reg(2'd0, 8'h00);
    idle(); ALU_OP = 3'd1; FLAG_WE = 1; REG_WE = 1; REG_SRC = 2'b01; step();
    idle(); DB_OUT_SRC = 3'd4; step();
    idle(); step();

    // stack wrap both directions
    set_reg(2'd1, 8'h00);
    idle(); REG_SEL = 2'd1; SP_CTRL = 2'b11; step();
    idle(); SP_CTRL = 2'b01; AB_SRC = 2'b10; step();
    idle(); REG_SEL = 2'd2; REG_WE = 1; REG_SRC = 2'b11; AB_SRC = 2'b11; step();
    idle(); REG_SEL = 2'd2; SP_CTRL = 2'b10; AB_SRC = 2'b10; step();
    idle(); REG_SEL = 2'd2; REG_WE = 1; REG_SRC = 2'b11; AB_SRC = 2'b11; step();
    idle(); REG_SEL = 2'd2; AB_SRC = 2'b11; step();

    // randomized traffic
    repeat (400) begin
      IR_WE      = 1'($urandom_range(0, 1));
      PC_CTRL    = 2'($urandom_range(0, 3));
      REG_SEL    = 2'($urandom_range(0, 3));
      REG_WE     = 1'($urandom_range(0, 1));
      REG_SRC    = 2'($urandom_range(0, 3));
      T_WE       = 1'($urandom_range(0, 1));
      ALU_OP     = 3'($urandom_range(0, 7));
      FLAG_WE    = 1'($urandom_range(0, 1));
      SP_CTRL    = 2'($urandom_range(0, 3));
      AB_SRC     = 2'($urandom_range(0, 3));
      DB_OUT_SRC = 3'($urandom_range(0, 7));
      DB_IN      = 8'($urandom_range(0, 255));
      step();
    end

    // asynchronous reset in the middle of a fixup
    set_reg(2'd0, 8'h7F); set_t(8'h01);
    idle(); ALU_OP = 3'd0; FLAG_WE = 1; step();
    set_pc(16'h10F0); set_t(8'h20); branch();
    drain();
    chk("busy_in_fix", int'(BUSY), 1);
    idle(); DB_OUT_SRC = 3'd2;
    #1 RES = 1'b1;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_flag", int'(FLAG), 0);
    chk("rst_pcl", int'(DB_OUT), 0);
    chk("rst_ab", int'(AB), 0);
    DB_OUT_SRC = 3'd3;
    #1;
    chk("rst_pch", int'(DB_OUT), 0);
    @(posedge CLK); #2;
    RES = 1'b0;
    model_reset();
    idle(); REG_SEL = 2'd3; REG_WE = 1; REG_SRC = 2'b11; step();
    idle(); REG_SEL = 2'd3; step();
    idle(); PC_CTRL = 2'b01; step();

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
